soc_clk_enable_gen: RTL and testbench

//  Parametrised multi-channel fractional clock-enable generator (NCO bank) driven from
//  one PLL output clock. Each channel gets a phase increment and produces single-cycle

---
 rtl/soc_clk_enable_gen.sv | 135 +++++++++++++
 tb/tb_soc_clk_enable_gen.sv | 209 ++++++++++++++++++++
 2 files changed

// File: rtl/soc_clk_enable_gen.sv
// soc_clk_enable_gen
//   Bank of NUM_CH independent phase-accumulator clock-enable generators, all
//   running from refclk. Each channel emits a one-cycle ce strobe on every
//   accumulator overflow (rate f_ref*inc/2^ACC_W), a square wave that flips on
//   each strobe, and a lock flag once LOCK_CNT strobes have followed the last
//   increment change. Increment changes on a running channel are staged in a
//   shadow register and applied at the channel's next carry, so the phase is
//   never disturbed.

module soc_clk_enable_gen #(
    parameter int unsigned NUM_CH   = 4,   // 1..16
    parameter int unsigned ACC_W    = 32,  // 4..48
    parameter int unsigned CH_W     = 2,   // must cover clog2(NUM_CH)
    parameter int unsigned LOCK_CNT = 16   // 1..255
) (
    input  logic              refclk,
    input  logic              rst,
    input  logic              cfg_wr,
    input  logic [CH_W-1:0]   cfg_ch,
    input  logic [ACC_W-1:0]  cfg_inc,
    input  logic              cfg_en,
    input  logic              pause,
    output logic [NUM_CH-1:0] ce,
    output logic [NUM_CH-1:0] tog,
    output logic [NUM_CH-1:0] locked,
    output logic [NUM_CH-1:0] cfg_busy
);

    typedef enum logic [1:0] {
        CH_IDLE = 2'd0,  // disabled, accumulator parked at zero
        CH_RUN  = 2'd1,  // accumulating with the active increment
        CH_PEND = 2'd2   // accumulating, new increment waiting for a carry
    } ch_state_t;

    localparam logic [7:0] LOCK_TH = 8'(LOCK_CNT);

    for (genvar g = 0; g < NUM_CH; g++) begin : g_ch
        localparam logic [CH_W-1:0] CH_ID = CH_W'(g);

        ch_state_t        state_q, state_d;
        logic [ACC_W-1:0] acc_q, acc_d;
        logic [ACC_W-1:0] inc_q, inc_d;
        logic [ACC_W-1:0] shadow_q, shadow_d;
        logic [ACC_W:0]   sum;
        logic [7:0]       lock_q, lock_d;
        logic             ce_q, ce_d;
        logic             tog_q, tog_d;
        logic             locked_q;
        logic             busy_q;
        logic             wr_hit;
        logic             step;

        assign wr_hit = cfg_wr && (cfg_ch == CH_ID);
        assign step   = (state_q != CH_IDLE) && !pause;
        assign sum    = {1'b0, acc_q} + {1'b0, inc_q};

        // Next-state: config writes, accumulation, shadow apply and lock counting
        always_comb begin
            state_d  = state_q;
            acc_d    = acc_q;
            inc_d    = inc_q;
            shadow_d = shadow_q;
            tog_d    = tog_q;
            lock_d   = lock_q;
            ce_d     = 1'b0;

            if (wr_hit && !cfg_en) begin
                state_d  = CH_IDLE;
                acc_d    = '0;
                tog_d    = 1'b0;
                lock_d   = '0;
                shadow_d = '0;
            end else if (wr_hit && (state_q == CH_IDLE)) begin
                state_d = CH_RUN;
                inc_d   = cfg_inc;
                acc_d   = '0;
                tog_d   = 1'b0;
                lock_d  = '0;
            end else begin
                if (step) begin
                    acc_d = sum[ACC_W-1:0];
                    ce_d  = sum[ACC_W];
                    if (sum[ACC_W]) begin
                        tog_d = ~tog_q;
                        if (state_q == CH_PEND) begin
                            inc_d   = shadow_q;
                            state_d = CH_RUN;
                            lock_d  = '0;
                        end else if (lock_q != '1) begin
                            lock_d = lock_q + 8'd1;
                        end
                    end
                end
                // A write landing on a carry edge: the carry above has already
                // used (and possibly applied) the old values; the new increment
                // is staged afterwards and waits for the following carry.
                if (wr_hit) begin
                    shadow_d = cfg_inc;
                    state_d  = CH_PEND;
                end
            end
        end

        // Channel register bank; every output comes straight from a flop
        always_ff @(posedge refclk or posedge rst) begin
            if (rst) begin
                state_q  <= CH_IDLE;
                acc_q    <= '0;
                inc_q    <= '0;
                shadow_q <= '0;
                lock_q   <= '0;
                ce_q     <= 1'b0;
                tog_q    <= 1'b0;
                locked_q <= 1'b0;
                busy_q   <= 1'b0;
            end else begin
                state_q  <= state_d;
                acc_q    <= acc_d;
                inc_q    <= inc_d;
                shadow_q <= shadow_d;
                lock_q   <= lock_d;
                ce_q     <= ce_d;
                tog_q    <= tog_d;
                locked_q <= (lock_d >= LOCK_TH);
                busy_q   <= (state_d == CH_PEND);
            end
        end

        assign ce[g]       = ce_q;
        assign tog[g]      = tog_q;
        assign locked[g]   = locked_q;
        assign cfg_busy[g] = busy_q;
    end

endmodule

// File: tb/tb_soc_clk_enable_gen.sv
// Directed bench for soc_clk_enable_gen with ACC_W=8, NUM_CH=4, LOCK_CNT=4.
// A second instance with CH_W=3 only ever sees channel numbers 4..7.

module tb_soc_clk_enable_gen;

    localparam int unsigned NUM_CH   = 4;
    localparam int unsigned ACC_W    = 8;
    localparam int unsigned CH_W     = 2;
    localparam int unsigned LOCK_CNT = 4;

    logic       refclk = 1'b0;
    logic       rst;
    logic       cfg_wr;
    logic [1:0] cfg_ch;
    logic [7:0] cfg_inc;
    logic       cfg_en;
    logic       pause;
    logic [3:0] ce, tog, locked, cfg_busy;

    logic [2:0] ch3b;
    logic [3:0] ce2, tog2, locked2, busy2;

    int n_cmp;
    int n_err;
    int cyc;
    int nstrobe;

    always #5 refclk = ~refclk;

    assign ch3b = 3'd4 + {1'b0, cfg_ch};

    soc_clk_enable_gen #(
        .NUM_CH(NUM_CH), .ACC_W(ACC_W), .CH_W(CH_W), .LOCK_CNT(LOCK_CNT)
    ) dut (
        .refclk(refclk), .rst(rst), .cfg_wr(cfg_wr), .cfg_ch(cfg_ch),
        .cfg_inc(cfg_inc), .cfg_en(cfg_en), .pause(pause),
        .ce(ce), .tog(tog), .locked(locked), .cfg_busy(cfg_busy)
    );

    soc_clk_enable_gen #(
        .NUM_CH(NUM_CH), .ACC_W(ACC_W), .CH_W(3), .LOCK_CNT(LOCK_CNT)
    ) dut2 (
        .refclk(refclk), .rst(rst), .cfg_wr(cfg_wr), .cfg_ch(ch3b),
        .cfg_inc(cfg_inc), .cfg_en(cfg_en), .pause(pause),
        .ce(ce2), .tog(tog2), .locked(locked2), .cfg_busy(busy2)
    );

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s @cyc %0d: observed %0h expected %0h", tag, cyc, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge refclk);
        #1;
        cyc++;
    endtask

    task automatic wr(input logic [1:0] ch, input logic [7:0] inc, input logic en);
        cfg_wr  = 1'b1;
        cfg_ch  = ch;
        cfg_inc = inc;
        cfg_en  = en;
        tick();
        cfg_wr  = 1'b0;
        cfg_en  = 1'b0;
        cfg_inc = '0;
    endtask

    // ch1 (inc=0x30) written at cyc 17: strobe when floor(48*j/256) steps
    function automatic logic ce1_exp(input int c);
        int j;
        j = c - 17;
        return ((48 * j) / 256) != ((48 * (j - 1)) / 256);
    endfunction

    initial begin
        n_cmp = 0; n_err = 0; cyc = 0; nstrobe = 0;
        rst = 1'b1; cfg_wr = 1'b0; cfg_ch = '0; cfg_inc = '0; cfg_en = 1'b0; pause = 1'b0;

        // reset state
        repeat (3) tick();
        check("rst_ce", ce, 4'h0);
        check("rst_tog", tog, 4'h0);
        check("rst_locked", locked, 4'h0);
        check("rst_busy", cfg_busy, 4'h0);
        rst = 1'b0;
        tick();
        check("idle_ce", ce, 4'h0);
        check("d2_idle", {ce2, tog2, locked2, busy2}, 16'h0);

        // 1: ch0 inc=0x40 -> period 4, tog period 8, locked with the 4th strobe
        wr(2'd0, 8'h40, 1'b1);
        cyc = 0;
        check("t1_ce0", ce, 4'h0);
        check("t1_busy0", cfg_busy, 4'h0);
        for (int k = 1; k <= 16; k++) begin
            tick();
            check("t1_ce", ce, 4'((cyc % 4) == 0));
            check("t1_tog", tog, 4'(((cyc / 4) % 2) == 1));
            check("t1_lock", locked, 4'(cyc >= 16));
        end

        // 2: ch1 inc=0x30 -> 48 strobes in 256 cycles, 6/5/5 spacing
        wr(2'd1, 8'h30, 1'b1);
        check("t2_ce_wr", ce, 4'h0);
        for (int j = 1; j <= 256; j++) begin
            tick();
            check("t2_ce", ce, {2'b00, ce1_exp(cyc), 1'((cyc % 4) == 0)});
            check("t2_lock1", locked[1], 1'(j >= 22));
            if (ce[1]) nstrobe++;
        end
        check("t2_count", nstrobe, 48);

        // 3: ch0 reprogram to 0x80 mid-period (acc=0x40 at cyc 273)
        wr(2'd0, 8'h80, 1'b1);                 // cyc 274
        check("t3_busy_a", cfg_busy, 4'h1);
        check("t3_ce_a", ce, 4'h0);
        check("t3_lock_a", locked, 4'h3);
        tick();                                 // cyc 275
        check("t3_busy_b", cfg_busy, 4'h1);
        check("t3_ce_b", ce, 4'h0);
        check("t3_tog_b", tog[0], 1'b0);
        tick();                                 // cyc 276: carry with old inc, apply
        check("t3_busy_c", cfg_busy, 4'h0);
        check("t3_ce_c", ce[0], 1'b1);
        check("t3_tog_c", tog[0], 1'b1);
        check("t3_lock_c", locked, 4'h2);
        for (int m = 277; m <= 290; m++) begin
            tick();
            check("t3_ce0", ce[0], 1'((cyc % 2) == 0));
            check("t3_ce1", ce[1], ce1_exp(cyc));
            check("t3_tog0", tog[0], 1'((((cyc - 276) / 2) % 2) == 0));
            check("t3_lock0", locked[0], 1'(cyc >= 284));
            check("t3_busy", cfg_busy, 4'h0);
        end

        // 4: pause for 10 edges with ch0 frozen at acc=0x80; disable ch1 meanwhile
        tick();                                 // cyc 291
        check("t4_pre_ce", ce, 4'h0);
        pause = 1'b1;
        for (int p = 0; p < 3; p++) begin       // cyc 292..294
            tick();
            check("t4_ce_hold", ce, 4'h0);
            check("t4_tog_hold", tog, 4'h2);
            check("t4_lock_hold", locked, 4'h3);
        end
        wr(2'd1, 8'h00, 1'b0);                  // cyc 295, still paused
        check("t4_dis_ce", ce, 4'h0);
        check("t4_dis_tog", tog, 4'h0);
        check("t4_dis_lock", locked, 4'h1);
        check("t4_dis_busy", cfg_busy, 4'h0);
        for (int p = 0; p < 6; p++) begin       // cyc 296..301
            tick();
            check("t4_ce_p", ce, 4'h0);
            check("t4_tog_p", tog, 4'h0);
        end
        pause = 1'b0;
        for (int p = 0; p < 8; p++) begin       // cyc 302..309
            tick();
            check("t4_resume", ce, 4'((cyc % 2) == 0));
        end

        // 5: disable write to idle ch3, plus channels 4..7 on the CH_W=3 instance
        wr(2'd3, 8'hFF, 1'b0);                  // cyc 310
        check("t5_ce", ce, 4'h1);
        check("t5_tog3", tog[3], 1'b0);
        check("t5_busy", cfg_busy, 4'h0);
        check("t5_lock", locked, 4'h1);
        for (int p = 0; p < 2; p++) begin       // cyc 311..312
            tick();
            check("t5_ce_after", ce, 4'((cyc % 2) == 0));
        end
        check("d2_quiet", {ce2, tog2, locked2, busy2}, 16'h0);

        // 6: async reset between edges while ch0 holds a pending increment
        wr(2'd0, 8'h40, 1'b1);                  // cyc 313
        check("t6_busy", cfg_busy, 4'h1);
        check("t6_lock_pre", locked, 4'h1);
        #3;
        rst = 1'b1;
        #1;
        check("t6_rst_ce", ce, 4'h0);
        check("t6_rst_tog", tog, 4'h0);
        check("t6_rst_lock", locked, 4'h0);
        check("t6_rst_busy", cfg_busy, 4'h0);
        #2;
        rst = 1'b0;
        for (int p = 0; p < 20; p++) begin
            tick();
            check("t6_quiet", {ce, tog, locked, cfg_busy}, 16'h0);
        end
        wr(2'd2, 8'h80, 1'b1);
        check("t6_re_a", ce, 4'h0);
        tick();
        check("t6_re_b", ce, 4'h0);
        tick();
        check("t6_re_c", ce, 4'h4);
        check("t6_re_tog", tog, 4'h4);
        check("d2_end", {ce2, tog2, locked2, busy2}, 16'h0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
